// File: rtl/coin_pkg.sv
// Shared geometry constants and types for the coin sprite path.
package coin_pkg;

    localparam int unsigned FRAME_W     = 32;
    localparam int unsigned FRAME_H     = 32;
    localparam int unsigned NUM_FRAMES  = 8;
    localparam int unsigned SHEET_W     = FRAME_W * NUM_FRAMES;
    localparam int unsigned SCREEN_W    = 640;
    localparam int unsigned SCREEN_H    = 480;
    localparam int unsigned FRAME_IDX_W = $clog2(NUM_FRAMES);

    typedef logic [9:0]             coord_t;
    typedef logic [FRAME_IDX_W-1:0] frame_t;

    typedef enum logic [1:0] {
        VIS_SHOWN,
        VIS_BLINK,
        VIS_HIDDEN
    } vis_state_t;

endpackage

// File: rtl/coin_anim_timer.sv
// Vsync-driven animation timer: frame tick, animation frame index, position latch and
// coin visibility. COIN_BLINK_EN selects the blink-out sequence on collect.
module coin_anim_timer
    import coin_pkg::*;
#(
    parameter int unsigned TICKS_PER_FRAME = 6
) (
    input  logic                   vga_clk,
    input  logic                   reset_n,
    input  logic                   vs,
    input  logic                   enable,
    input  logic [9:0]             coin_x,
    input  logic [9:0]             coin_y,
    input  logic                   collected,
    input  logic                   respawn,
    output logic [9:0]             pos_x,
    output logic [9:0]             pos_y,
    output logic [FRAME_IDX_W-1:0] frame_idx,
    output logic                   visible
);

    localparam int unsigned    CNT_W    = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_FRAME - 1);

    logic             vs_q;
    logic             tick;
    logic             pend_collect;
    logic             pend_respawn;
    logic             collect_now;
    logic             respawn_now;
    logic [CNT_W-1:0] tick_cnt;
    vis_state_t       state_q;
    vis_state_t       state_d;
`ifdef COIN_BLINK_EN
    logic [3:0]       blink_q;
    logic [3:0]       blink_d;
`endif

    assign tick        = vs_q & ~vs;
    // A pulse landing on the tick cycle itself is applied at that tick.
    assign collect_now = pend_collect | collected;
    assign respawn_now = pend_respawn | respawn;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            vs_q         <= 1'b1;
            pend_collect <= 1'b0;
            pend_respawn <= 1'b0;
            pos_x        <= '0;
            pos_y        <= '0;
        end else begin
            vs_q <= vs;
            if (tick) begin
                pend_collect <= 1'b0;
                pend_respawn <= 1'b0;
                pos_x        <= coin_x;
                pos_y        <= coin_y;
            end else begin
                pend_collect <= pend_collect | collected;
                pend_respawn <= pend_respawn | respawn;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt  <= '0;
            frame_idx <= '0;
        end else if (tick) begin
            if (respawn_now) begin
                tick_cnt  <= '0;
                frame_idx <= '0;
            end else if (enable) begin
                if (tick_cnt == CNT_LAST) begin
                    tick_cnt  <= '0;
                    frame_idx <= frame_idx + 1'b1;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= VIS_SHOWN;
`ifdef COIN_BLINK_EN
            blink_q <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifdef COIN_BLINK_EN
            blink_q <= blink_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
`ifdef COIN_BLINK_EN
        blink_d = blink_q;
`endif
        if (tick) begin
            if (respawn_now) begin
                state_d = VIS_SHOWN;
            end else if (collect_now && (state_q == VIS_SHOWN)) begin
`ifdef COIN_BLINK_EN
                state_d = VIS_BLINK;
                blink_d = '0;
`else
                state_d = VIS_HIDDEN;
`endif
            end
`ifdef COIN_BLINK_EN
            else if (state_q == VIS_BLINK) begin
                if (blink_q == 4'd15) begin
                    state_d = VIS_HIDDEN;
                end else begin
                    blink_d = blink_q + 4'd1;
                end
            end
`endif
        end
    end

`ifdef COIN_BLINK_EN
    // Blink phase: ticks 0-3 off, 4-7 on, 8-11 off, 12-15 on.
    assign visible = (state_q == VIS_SHOWN) | ((state_q == VIS_BLINK) & blink_q[2]);
`else
    assign visible = (state_q == VIS_SHOWN);
`endif

endmodule

// File: rtl/coin_sprite_animator.sv
// Coin sprite address generator: hit test, sheet address and pixel-aligned in_sprite.
// Optional blink-out on collect is enabled by defining COIN_BLINK_EN.
module coin_sprite_animator
    import coin_pkg::*;
#(
    parameter int unsigned TICKS_PER_FRAME = 6,
    parameter int unsigned ADDR_W          = 13
) (
    input  logic                   vga_clk,
    input  logic                   reset_n,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    input  logic                   blank,
    input  logic                   vs,
    input  logic                   enable,
    input  logic [9:0]             coin_x,
    input  logic [9:0]             coin_y,
    input  logic                   collected,
    input  logic                   respawn,
    output logic [ADDR_W-1:0]      rom_address,
    output logic                   in_sprite,
    output logic [FRAME_IDX_W-1:0] frame_idx,
    output logic                   visible
);

    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic [10:0] x_lim;
    logic [10:0] y_lim;
    logic        x_in;
    logic        y_in;
    logic        hit;
    logic [9:0]  dx;
    logic [9:0]  dy;

    coin_anim_timer #(
        .TICKS_PER_FRAME(TICKS_PER_FRAME)
    ) u_timer (
        .vga_clk   (vga_clk),
        .reset_n   (reset_n),
        .vs        (vs),
        .enable    (enable),
        .coin_x    (coin_x),
        .coin_y    (coin_y),
        .collected (collected),
        .respawn   (respawn),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .frame_idx (frame_idx),
        .visible   (visible)
    );

    // 11-bit bounds so a coin near the right/bottom edge clips instead of wrapping.
    assign x_lim = {1'b0, pos_x} + 11'(FRAME_W);
    assign y_lim = {1'b0, pos_y} + 11'(FRAME_H);
    assign x_in  = ({1'b0, DrawX} >= {1'b0, pos_x}) && ({1'b0, DrawX} < x_lim);
    assign y_in  = ({1'b0, DrawY} >= {1'b0, pos_y}) && ({1'b0, DrawY} < y_lim);
    assign hit   = blank & visible & x_in & y_in;

    assign dx = DrawX - pos_x;
    assign dy = DrawY - pos_y;

    // Combinational: the ROM captures this on the falling edge of vga_clk.
    always_comb begin
        rom_address = '0;
        if (hit) begin
            rom_address = ADDR_W'(32'(frame_idx) * FRAME_W + 32'(dx) + 32'(dy) * SHEET_W);
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            in_sprite <= 1'b0;
        end else begin
            in_sprite <= hit;
        end
    end

endmodule

// File: tb/tb_coin_sprite_animator.sv
// Scoreboard bench for coin_sprite_animator against a tick/step-count reference model.
module tb_coin_sprite_animator;

    localparam int TPF = 6;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [9:0]  DrawX, DrawY, coin_x, coin_y;
    logic        blank, vs, enable, collected, respawn;
    logic [12:0] rom_address;
    logic        in_sprite;
    logic [2:0]  frame_idx;
    logic        visible;

    always #5 vga_clk = ~vga_clk;

    coin_sprite_animator #(
        .TICKS_PER_FRAME(TPF),
        .ADDR_W(13)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .vs(vs), .enable(enable), .coin_x(coin_x), .coin_y(coin_y),
        .collected(collected), .respawn(respawn), .rom_address(rom_address),
        .in_sprite(in_sprite), .frame_idx(frame_idx), .visible(visible)
    );

    typedef struct {
        logic [12:0] addr;
        logic        ins;
        logic [2:0]  frame;
        logic        vis;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: position, cumulative enabled ticks since respawn, visibility.
    int m_px, m_py, m_steps;
    bit m_vis, m_pc, m_pr, m_vs_prev, m_last_hit;
    bit en_r;
    int cx_r, cy_r;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_px = 0; m_py = 0; m_steps = 0;
        m_vis = 1; m_pc = 0; m_pr = 0; m_vs_prev = 1; m_last_hit = 0;
    endfunction

    task automatic step(input int x, input int y, input bit b, input bit v,
                        input bit col, input bit resp);
        exp_t e;
        bit   hit;
        int   fr;
        @(posedge vga_clk);
        #1;
        DrawX = 10'(x); DrawY = 10'(y); blank = b; vs = v;
        collected = col; respawn = resp;
        enable = en_r; coin_x = 10'(cx_r); coin_y = 10'(cy_r);
        fr  = (m_steps / TPF) % 8;
        hit = b && m_vis && (x >= m_px) && (x < m_px + 32) && (y >= m_py) && (y < m_py + 32);
        e.addr  = hit ? 13'((fr * 32 + (x - m_px) + (y - m_py) * 256) % 8192) : 13'd0;
        e.ins   = m_last_hit;
        e.frame = 3'(fr);
        e.vis   = m_vis;
        sb_q.push_back(e);
        m_last_hit = hit;
        if (m_vs_prev && !v) begin
            m_px = cx_r; m_py = cy_r;
            if (m_pr || resp) begin
                m_vis = 1; m_steps = 0;
            end else begin
                if (m_pc || col) m_vis = 0;
                if (en_r) m_steps++;
            end
            m_pc = 0; m_pr = 0;
        end else begin
            m_pc = m_pc | col;
            m_pr = m_pr | resp;
        end
        m_vs_prev = v;
    endtask

    task automatic vs_tick();
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
    endtask

    task automatic scan_row(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) step(x, y, 1, 1, 0, 0);
    endtask

    // Monitor: one expected item per driven pixel, compared half a cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge vga_clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("rom_address", 32'(rom_address), 32'(e.addr));
                check("in_sprite",   32'(in_sprite),   32'(e.ins));
                check("frame_idx",   32'(frame_idx),   32'(e.frame));
                check("visible",     32'(visible),     32'(e.vis));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int x, y;
        reset_n = 1'b0; DrawX = '0; DrawY = '0; blank = 1'b1; vs = 1'b1;
        enable = 1'b0; collected = 1'b0; respawn = 1'b0;
        en_r = 0; cx_r = 100; cy_r = 50;
        coin_x = 10'd100; coin_y = 10'd50;
        model_reset();
        #12;
        check("reset_in_sprite", 32'(in_sprite), 0);
        check("reset_frame_idx", 32'(frame_idx), 0);
        check("reset_visible",   32'(visible),   1);
        check("reset_rom_addr",  32'(rom_address), 0);
        blank = 1'b0;
        @(negedge vga_clk);
        reset_n = 1'b1;

        // Latch (100,50), check top-left pixel and neighbours.
        vs_tick();
        step(100, 50, 1, 1, 0, 0);
        step(101, 50, 1, 1, 0, 0);
        step(99, 50, 1, 1, 0, 0);
        step(100, 50, 0, 1, 0, 0);

        // Advance to frame 2; bottom-right corner and just outside.
        en_r = 1;
        repeat (12) vs_tick();
        step(131, 81, 1, 1, 0, 0);
        step(132, 81, 1, 1, 0, 0);
        step(131, 82, 1, 1, 0, 0);
        step(100, 49, 1, 1, 0, 0);

        repeat (48) vs_tick();
        step(131, 81, 1, 1, 0, 0);
        en_r = 0;
        repeat (12) vs_tick();
        step(100, 50, 1, 1, 0, 0);
        en_r = 1;

        // Position change mid-frame only takes effect at the next tick.
        scan_row(60, 96, 236);
        cx_r = 200;
        scan_row(60, 96, 236);
        vs_tick();
        scan_row(60, 96, 236);

        // Collect mid-frame, then both pending together.
        step(0, 0, 0, 1, 1, 0);
        scan_row(60, 200, 205);
        vs_tick();
        scan_row(60, 198, 235);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0, 1);
        vs_tick();
        scan_row(61, 198, 233);

        // Collect coinciding with the tick cycle.
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        scan_row(61, 198, 203);
        step(0, 0, 0, 1, 0, 1);
        vs_tick();

        // Bottom-right clipping, no wrap to column/row 0.
        cx_r = 620; cy_r = 470;
        vs_tick();
        for (int r = 466; r <= 479; r++) begin
            scan_row(r, 0, 6);
            scan_row(r, 614, 639);
        end
        for (int r = 0; r <= 2; r++) scan_row(r, 616, 639);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) en_r = !en_r;
            if ($urandom_range(0, 299) == 0) begin
                cx_r = int'($urandom_range(0, 639));
                cy_r = int'($urandom_range(0, 479));
            end
            if ($urandom_range(0, 1) == 1) begin
                x = (m_px + int'($urandom_range(0, 39)) - 4) & 1023;
                y = (m_py + int'($urandom_range(0, 39)) - 4) & 1023;
            end else begin
                x = int'($urandom_range(0, 639));
                y = int'($urandom_range(0, 479));
            end
            step(x, y, $urandom_range(0, 7) != 0, $urandom_range(0, 15) != 0,
                 $urandom_range(0, 59) == 0, $urandom_range(0, 99) == 0);
        end

        // Asynchronous reset while in_sprite is high.
        step(0, 0, 0, 1, 0, 1);
        vs_tick();
        step(m_px + 3, m_py + 2, 1, 1, 0, 0);
        @(negedge vga_clk);
        @(posedge vga_clk);
        #1;
        check("pre_reset_in_sprite", 32'(in_sprite), 32'(m_last_hit));
        reset_n = 1'b0;
        #1;
        check("async_rst_in_sprite", 32'(in_sprite), 0);
        check("async_rst_frame_idx", 32'(frame_idx), 0);
        check("async_rst_visible",   32'(visible),   1);
        blank = 1'b0;
        @(negedge vga_clk);
        reset_n = 1'b1;
        @(negedge vga_clk);
        check("scoreboard_drained", 32'(sb_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
